// File: rtl/bcd_to_binary.sv
// Serial BCD-to-binary converter: accepts digits MSD first and emits an 8-bit
// result with saturating overflow and malformed-number error flags.
module bcd_to_binary #(
   parameter int unsigned MAX_DIGITS = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       digit_last,
   output logic [7:0] binary,
   output logic       binary_valid,
   output logic       overflow,
   output logic       error,
   output logic       busy
);

   localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

   typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;

   state_t          state_q, state_d;
   logic [9:0]      acc_q, acc_d;
   logic            ovf_q, ovf_d;
   logic            err_q, err_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      binary_q, binary_d;
   logic            binary_valid_q, binary_valid_d;
   logic            overflow_q, overflow_d;
   logic            error_q, error_d;
   logic            busy_q, busy_d;

   logic [13:0]     step;
   logic            bad_digit;
   logic            done;

   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      ovf_d          = ovf_q;
      err_d          = err_q;
      count_d        = count_q;
      binary_d       = binary_q;
      overflow_d     = overflow_q;
      error_d        = error_q;
      done           = 1'b0;
      bad_digit      = (digit > 4'd9);
      step           = ({4'd0, acc_q} * 14'd10) + {10'd0, digit};

      if (digit_valid) begin
         case (state_q)
            IDLE: begin
               acc_d   = {6'd0, digit};
               ovf_d   = 1'b0;
               err_d   = bad_digit;
               count_d = CW'(1);
               done    = digit_last;
               if (digit_last)     state_d = IDLE;
               else if (bad_digit) state_d = DISCARD;
               else                state_d = ACCUM;
            end
            ACCUM: begin
               // A digit beyond MAX_DIGITS is malformed whether or not it is the last one.
               if (bad_digit || (count_q == MAX_CNT)) begin
                  err_d   = 1'b1;
                  done    = digit_last;
                  state_d = digit_last ? IDLE : DISCARD;
               end else begin
                  count_d = count_q + CW'(1);
                  if (ovf_q || (step > 14'd255)) begin
                     ovf_d = 1'b1;
                     acc_d = 10'd256;
                  end else begin
                     acc_d = step[9:0];
                  end
                  done    = digit_last;
                  state_d = digit_last ? IDLE : ACCUM;
               end
            end
            DISCARD: begin
               if (digit_last) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      binary_valid_d = done;
      if (done) begin
         if (err_d) begin
            binary_d   = '0;
            overflow_d = 1'b0;
            error_d    = 1'b1;
         end else if (ovf_d) begin
            binary_d   = '1;
            overflow_d = 1'b1;
            error_d    = 1'b0;
         end else begin
            binary_d   = acc_d[7:0];
            overflow_d = 1'b0;
            error_d    = 1'b0;
         end
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         acc_q          <= '0;
         ovf_q          <= 1'b0;
         err_q          <= 1'b0;
         count_q        <= '0;
         binary_q       <= '0;
         binary_valid_q <= 1'b0;
         overflow_q     <= 1'b0;
         error_q        <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         ovf_q          <= ovf_d;
         err_q          <= err_d;
         count_q        <= count_d;
         binary_q       <= binary_d;
         binary_valid_q <= binary_valid_d;
         overflow_q     <= overflow_d;
         error_q        <= error_d;
         busy_q         <= busy_d;
      end
   end

   assign binary       = binary_q;
   assign binary_valid = binary_valid_q;
   assign overflow     = overflow_q;
   assign error        = error_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: vector table of whole numbers plus
// hand-written back-to-back, gap and mid-number reset sequences.
module tb_bcd_to_binary;

   logic       clock;
   logic       reset_n;
   logic       digit_valid;
   logic [3:0] digit;
   logic       digit_last;
   logic [7:0] binary;
   logic       binary_valid;
   logic       overflow;
   logic       error;
   logic       busy;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   bcd_to_binary #(.MAX_DIGITS(3)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .digit_valid  (digit_valid),
      .digit        (digit),
      .digit_last   (digit_last),
      .binary       (binary),
      .binary_valid (binary_valid),
      .overflow     (overflow),
      .error        (error),
      .busy         (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // digits[i*4 +: 4] is the i-th digit sent (most significant first)
   typedef struct {
      logic [15:0] digits;
      int unsigned n;
      logic [7:0]  exp_bin;
      logic        exp_ovf;
      logic        exp_err;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Presents one digit for one edge, leaving the bench on the following negedge.
   task automatic send(input logic [3:0] d, input logic last);
      digit_valid = 1'b1;
      digit       = d;
      digit_last  = last;
      @(negedge clock);
      digit_valid = 1'b0;
      digit_last  = 1'b0;
      digit       = 4'd0;
   endtask

   task automatic check_result(input string name, input logic [7:0] b, input logic o, input logic e);
      check({name, ".valid"}, 32'(binary_valid), 32'd1);
      check({name, ".binary"}, 32'(binary), 32'(b));
      check({name, ".overflow"}, 32'(overflow), 32'(o));
      check({name, ".error"}, 32'(error), 32'(e));
      check({name, ".busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{16'h0552, 3, 8'd255, 1'b0, 1'b0};
      vecs[1]  = '{16'h0652, 3, 8'hFF,  1'b1, 1'b0};
      vecs[2]  = '{16'h0999, 3, 8'hFF,  1'b1, 1'b0};
      vecs[3]  = '{16'h03A1, 3, 8'd0,   1'b0, 1'b1};
      vecs[4]  = '{16'h4321, 4, 8'd0,   1'b0, 1'b1};
      vecs[5]  = '{16'h0007, 1, 8'd7,   1'b0, 1'b0};
      vecs[6]  = '{16'h0000, 1, 8'd0,   1'b0, 1'b0};
      vecs[7]  = '{16'h0821, 3, 8'd128, 1'b0, 1'b0};
      vecs[8]  = '{16'h0062, 2, 8'd26,  1'b0, 1'b0};
      vecs[9]  = '{16'h000F, 1, 8'd0,   1'b0, 1'b1};
      vecs[10] = '{16'h0099, 2, 8'd99,  1'b0, 1'b0};
      vecs[11] = '{16'h0500, 3, 8'd5,   1'b0, 1'b0};
      vecs[12] = '{16'h0F21, 3, 8'd0,   1'b0, 1'b1};
      vecs[13] = '{16'h0003, 3, 8'hFF,  1'b1, 1'b0};

      reset_n     = 1'b0;
      digit_valid = 1'b0;
      digit       = 4'd0;
      digit_last  = 1'b0;
      repeat (2) @(negedge clock);
      check("reset.binary", 32'(binary), 32'd0);
      check("reset.valid", 32'(binary_valid), 32'd0);
      check("reset.overflow", 32'(overflow), 32'd0);
      check("reset.error", 32'(error), 32'd0);
      check("reset.busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      for (int v = 0; v < 14; v++) begin
         for (int unsigned i = 0; i < vecs[v].n; i++) begin
            logic [3:0] d;
            d = vecs[v].digits[i*4 +: 4];
            send(d, (i == vecs[v].n - 1));
            if (i != vecs[v].n - 1) begin
               check($sformatf("vec%0d.d%0d.valid", v, i), 32'(binary_valid), 32'd0);
               check($sformatf("vec%0d.d%0d.busy", v, i), 32'(busy), 32'd1);
            end
         end
         check_result($sformatf("vec%0d", v), vecs[v].exp_bin, vecs[v].exp_ovf, vecs[v].exp_err);
         @(negedge clock);
         check($sformatf("vec%0d.pulse_end", v), 32'(binary_valid), 32'd0);
         check($sformatf("vec%0d.hold", v), 32'(binary), 32'(vecs[v].exp_bin));
      end

      // Back-to-back: 4(last) then 1 presented while the pulse is high, gap, 0(last).
      send(4'd4, 1'b1);
      check_result("b2b.first", 8'd4, 1'b0, 1'b0);
      send(4'd1, 1'b0);
      check("b2b.mid.valid", 32'(binary_valid), 32'd0);
      check("b2b.mid.busy", 32'(busy), 32'd1);
      for (int g = 0; g < 5; g++) begin
         digit_last = 1'b1;
         digit      = 4'd9;
         @(negedge clock);
         check($sformatf("gap%0d.valid", g), 32'(binary_valid), 32'd0);
         check($sformatf("gap%0d.busy", g), 32'(busy), 32'd1);
      end
      digit_last = 1'b0;
      send(4'd0, 1'b1);
      check_result("b2b.second", 8'd10, 1'b0, 1'b0);
      @(negedge clock);

      // Reset mid-number discards the partial 1,2.
      send(4'd1, 1'b0);
      send(4'd2, 1'b0);
      check("abort.busy_pre", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("abort.binary", 32'(binary), 32'd0);
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.valid", 32'(binary_valid), 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("abort.no_pulse", 32'(binary_valid), 32'd0);
      send(4'd9, 1'b1);
      check_result("abort.after", 8'd9, 1'b0, 1'b0);
      @(negedge clock);
      check("abort.after_end", 32'(binary_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_to_binary.md
BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 Parameter MAX_DIGITS, default 3: maximum decimal digits per number.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 digit_valid  input  1  digit presented this cycle, most significant digit first.
REQ-005 digit  input  4  BCD digit value; legal range 0-9.
REQ-006 digit_last  input  1  qualified by digit_valid; marks the final (least significant) digit of the number.
REQ-007 binary  output  8  converted value; holds until the next result.
REQ-008 binary_valid  output  1  one-cycle pulse when binary/overflow/error are updated.
REQ-009 overflow  output  1  the decimal value exceeded 255; holds with binary.
REQ-010 error  output  1  malformed number (bad digit or too many digits); holds with binary.
REQ-011 busy  output  1  high while a number is partially received (state ACCUM or DISCARD).

Function
REQ-012 States SHALL be IDLE, ACCUM, DISCARD; there is no ready signal, so every digit_valid cycle is consumed.
REQ-013 Accumulator SHALL be 10 bits plus a sticky overflow bit; the per-digit update SHALL be acc = acc*10 + digit.
REQ-014 The first digit of a number (state IDLE) SHALL load acc = digit, clear sticky overflow, and set the digit count to 1.
REQ-015 If acc*10 + digit > 255 at any step, the sticky overflow SHALL set and acc SHALL saturate at 256 (no wrap).
REQ-016 IDLE -> ACCUM on a legal digit without digit_last; IDLE stays IDLE on a legal digit with digit_last (single-digit number).
REQ-017 ACCUM stays ACCUM on a legal non-last digit while count < MAX_DIGITS; returns to IDLE on a legal last digit.
REQ-018 digit > 9 in IDLE or ACCUM SHALL set a sticky error; next state DISCARD, or IDLE if digit_last is high on that digit.
REQ-019 A non-last digit arriving when count == MAX_DIGITS SHALL set the sticky error and enter DISCARD.
REQ-020 DISCARD SHALL ignore digit values and return to IDLE on digit_valid with digit_last.
REQ-021 Completion: binary_valid SHALL be high for exactly the cycle after the edge that accepted the last digit.
REQ-022 On completion: error=1 -> binary=0, overflow=0; else overflow=1 -> binary=8'hFF; else binary=acc[7:0], overflow=0, error=0.
REQ-023 A new digit accepted in the same cycle that binary_valid is high SHALL be processed normally (back-to-back numbers, zero bubble).
REQ-024 Cycles with digit_valid=0 SHALL leave all state unchanged, including mid-number gaps of any length.
REQ-025 digit_last with digit_valid=0 SHALL be ignored.
REQ-026 busy SHALL be a registered function of state only: high in ACCUM and DISCARD, low in IDLE.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, acc=0, count=0, sticky flags=0, binary=0, binary_valid=0, overflow=0, error=0, busy=0.
REQ-028 Reset asserted mid-number SHALL discard the partial number; no binary_valid pulse SHALL follow reset release.
REQ-029 The first digit_valid at least one edge after reset_n deasserts SHALL be treated as the first digit of a number.

Verification
REQ-030 Digits 2,5,5 (last on 5) -> next cycle binary_valid=1, binary=255, overflow=0, error=0; busy high between digits.
REQ-031 Digits 2,5,6 (last) -> binary=8'hFF, overflow=1, error=0; digits 9,9,9 also -> 8'hFF, overflow=1.
REQ-032 Digits 1,A,3 (last) -> binary=0, error=1; binary_valid pulses only once, after the '3'.
REQ-033 Digits 1,2,3,4 with last only on 4 (MAX_DIGITS=3) -> error=1 and binary=0 after the '4'; single digit 7 with last -> binary=7 one cycle later.
REQ-034 Back-to-back: 4(last) immediately followed by 1,0(last), with idle gaps of 5 cycles inside the second number -> pulses with binary=4 then binary=10.
REQ-035 Digits 1,2 then reset_n low for 2 cycles, then 9(last) -> binary=9, no pulse from the aborted number.
